// File: rtl/exu_pipelined.sv
// exu_pipelined: valid/ready execute stage with single-cycle ALU/branch, iterative divider and result FIFO.
// Build option: define EXU_PIPELINED_EARLY_OUT_EN to skip the divide loop when |rs1| < |rs2|.
package exu_pipelined_pkg;
    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_LUI, OP_AUIPC,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;
endpackage

module exu_pipelined
    import exu_pipelined_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_UNROLL = 1,
    parameter int OUT_DEPTH  = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  imm,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             busy
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int ITER  = XLEN / DIV_UNROLL;
    localparam int CNT_W = $clog2(ITER) + 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int FILL_W = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   dvd_q, dvd_d, rem_q, rem_d, dsr_q, dsr_d;
    logic              quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d, want_rem_q, want_rem_d;
    logic [TAG_W-1:0]  div_tag_q, div_tag_d;
    logic [XLEN-1:0]   data_mem_q [OUT_DEPTH];
    logic [XLEN-1:0]   data_mem_d [OUT_DEPTH];
    logic [TAG_W-1:0]  tag_mem_q [OUT_DEPTH];
    logic [TAG_W-1:0]  tag_mem_d [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

    logic              is_imm, is_branch, is_div, alu_push, taken, mispredict;
    logic [XLEN-1:0]   opb, alu_res, pc_plus4, jalr_sum, br_target, next_pc;
    logic [SH_W-1:0]   shamt;
    logic              sgn_op, div_zero, div_ovf, div_early;
    logic [XLEN-1:0]   abs1, abs2, fix_quo, fix_rem, fix_res;
    logic [XLEN:0]     step_rem;
    logic [XLEN-1:0]   step_quo;
    logic              pop, space, accept, push_en;
    logic [XLEN-1:0]   push_data;
    logic [TAG_W-1:0]  push_tag;

    always_comb begin
        is_imm    = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI,
                               OP_SLTI, OP_SLTIU};
        opb       = is_imm ? imm : rs2;
        shamt     = opb[SH_W-1:0];
        pc_plus4  = pc + XLEN'(4);
        jalr_sum  = rs1 + imm;
        br_target = pc + imm;
        is_branch = 1'b0;
        is_div    = 1'b0;
        alu_push  = 1'b1;
        taken     = 1'b0;
        alu_res   = '0;
        case (op)
            OP_ADD, OP_ADDI:   alu_res = rs1 + opb;
            OP_SUB:            alu_res = rs1 - rs2;
            OP_AND, OP_ANDI:   alu_res = rs1 & opb;
            OP_OR, OP_ORI:     alu_res = rs1 | opb;
            OP_XOR, OP_XORI:   alu_res = rs1 ^ opb;
            OP_SLL, OP_SLLI:   alu_res = rs1 << shamt;
            OP_SRL, OP_SRLI:   alu_res = rs1 >> shamt;
            OP_SRA, OP_SRAI:   alu_res = $signed(rs1) >>> shamt;
            OP_SLT, OP_SLTI:   alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(opb)};
            OP_SLTU, OP_SLTIU: alu_res = {{(XLEN-1){1'b0}}, rs1 < opb};
            OP_LUI:            alu_res = imm;
            OP_AUIPC:          alu_res = pc + imm;
            OP_BEQ:  begin is_branch = 1'b1; alu_push = 1'b0; taken = (rs1 == rs2); end
            OP_BNE:  begin is_branch = 1'b1; alu_push = 1'b0; taken = (rs1 != rs2); end
            OP_BLT:  begin is_branch = 1'b1; alu_push = 1'b0; taken = ($signed(rs1) < $signed(rs2)); end
            OP_BGE:  begin is_branch = 1'b1; alu_push = 1'b0; taken = ($signed(rs1) >= $signed(rs2)); end
            OP_BLTU: begin is_branch = 1'b1; alu_push = 1'b0; taken = (rs1 < rs2); end
            OP_BGEU: begin is_branch = 1'b1; alu_push = 1'b0; taken = (rs1 >= rs2); end
            OP_JAL:  begin is_branch = 1'b1; taken = 1'b1; alu_res = pc_plus4; end
            OP_JALR: begin
                is_branch = 1'b1;
                taken     = 1'b1;
                alu_res   = pc_plus4;
                br_target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin is_div = 1'b1; alu_push = 1'b0; end
            default: alu_res = '0;
        endcase
        next_pc    = taken ? br_target : pc_plus4;
        mispredict = is_branch && ((taken != pred_taken) || (taken && (br_target != pred_target)));

        sgn_op   = (op == OP_DIV) || (op == OP_REM);
        abs1     = (sgn_op && rs1[XLEN-1]) ? -rs1 : rs1;
        abs2     = (sgn_op && rs2[XLEN-1]) ? -rs2 : rs2;
        div_zero = (rs2 == '0);
        div_ovf  = sgn_op && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
`ifdef EXU_PIPELINED_EARLY_OUT_EN
        div_early = !div_zero && (abs1 < abs2);
`else
        div_early = 1'b0;
`endif
    end

    // Restoring division: DIV_UNROLL quotient bits shift into dvd as dividend bits shift out.
    always_comb begin
        step_rem = {1'b0, rem_q};
        step_quo = dvd_q;
        for (int i = 0; i < DIV_UNROLL; i++) begin
            step_rem = {step_rem[XLEN-1:0], step_quo[XLEN-1]};
            step_quo = {step_quo[XLEN-2:0], 1'b0};
            if (step_rem >= {1'b0, dsr_q}) begin
                step_rem    = step_rem - {1'b0, dsr_q};
                step_quo[0] = 1'b1;
            end
        end
        fix_quo = quo_neg_q ? -dvd_q : dvd_q;
        fix_rem = rem_neg_q ? -rem_q : rem_q;
        fix_res = want_rem_q ? fix_rem : fix_quo;
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        dvd_d            = dvd_q;
        rem_d            = rem_q;
        dsr_d            = dsr_q;
        quo_neg_d        = quo_neg_q;
        rem_neg_d        = rem_neg_q;
        want_rem_d       = want_rem_q;
        div_tag_d        = div_tag_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        push_en          = 1'b0;
        push_data        = '0;
        push_tag         = '0;
        pop              = out_ready && (fill_q != '0);
        space            = (fill_q != FILL_W'(OUT_DEPTH)) || pop;
        in_ready         = (state_q == S_IDLE) && !flush && space;
        accept           = in_valid && in_ready;

        case (state_q)
            S_IDLE: begin
                if (accept && is_div) begin
                    dvd_d      = abs1;
                    dsr_d      = abs2;
                    rem_d      = '0;
                    cnt_d      = '0;
                    quo_neg_d  = sgn_op && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                    rem_neg_d  = sgn_op && rs1[XLEN-1];
                    want_rem_d = (op == OP_REM) || (op == OP_REMU);
                    div_tag_d  = in_tag;
                    state_d    = S_DIV;
                    // Special cases load final raw results and bypass the loop.
                    if (div_zero || div_ovf || div_early) begin
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = S_FIX;
                        if (div_zero) begin
                            dvd_d = '1;
                            rem_d = rs1;
                        end else if (div_ovf) begin
                            dvd_d = rs1;
                            rem_d = '0;
                        end else begin
                            dvd_d = '0;
                            rem_d = rs1;
                        end
                    end
                end else if (accept) begin
                    push_en   = alu_push;
                    push_data = alu_res;
                    push_tag  = in_tag;
                    if (mispredict) begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = next_pc;
                    end
                end
            end
            S_DIV: begin
                dvd_d = step_quo;
                rem_d = step_rem[XLEN-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (space) begin
                    push_en   = 1'b1;
                    push_data = fix_res;
                    push_tag  = div_tag_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        data_mem_d = data_mem_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        if (push_en) begin
            data_mem_d[wr_ptr_q] = push_data;
            tag_mem_d[wr_ptr_q]  = push_tag;
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        case ({push_en, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase

        if (flush) begin
            state_d          = S_IDLE;
            fill_d           = '0;
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            redirect_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            dvd_q            <= '0;
            rem_q            <= '0;
            dsr_q            <= '0;
            quo_neg_q        <= 1'b0;
            rem_neg_q        <= 1'b0;
            want_rem_q       <= 1'b0;
            div_tag_q        <= '0;
            data_mem_q       <= '{default: '0};
            tag_mem_q        <= '{default: '0};
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fill_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            dvd_q            <= dvd_d;
            rem_q            <= rem_d;
            dsr_q            <= dsr_d;
            quo_neg_q        <= quo_neg_d;
            rem_neg_q        <= rem_neg_d;
            want_rem_q       <= want_rem_d;
            div_tag_q        <= div_tag_d;
            data_mem_q       <= data_mem_d;
            tag_mem_q        <= tag_mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            fill_q           <= fill_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_valid      = (fill_q != '0);
    assign out_data       = out_valid ? data_mem_q[rd_ptr_q] : '0;
    assign out_tag        = out_valid ? tag_mem_q[rd_ptr_q] : '0;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_exu_pipelined.sv
// tb_exu_pipelined: directed self-checking bench for exu_pipelined (XLEN=32, DIV_UNROLL=1, OUT_DEPTH=2).
`timescale 1ns/1ps
module tb_exu_pipelined;
    import exu_pipelined_pkg::*;

`ifdef EXU_PIPELINED_EARLY_OUT_EN
    localparam int LAT_EO = 2;
`else
    localparam int LAT_EO = 34;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, pred_taken;
    op_t         op;
    logic [31:0] pc, rs1, rs2, imm, pred_target;
    logic [3:0]  in_tag, out_tag;
    logic        out_valid, out_ready, redirect_valid, busy;
    logic [31:0] out_data, redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exu_pipelined #(.XLEN(32), .DIV_UNROLL(1), .OUT_DEPTH(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .in_tag(in_tag),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
        in_valid    = 1'b1;
        op          = o;
        rs1         = a;
        rs2         = b;
        imm         = i;
        pc          = p;
        in_tag      = t;
        pred_taken  = 1'b0;
        pred_target = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = OP_ADD; pc = '0; rs1 = '0; rs2 = '0; imm = '0; in_tag = '0;
        pred_taken = 1'b0; pred_target = '0;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_out_tag: got %h expected 0", out_tag); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_redirect_valid: got %b expected 0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    // One instruction per cycle; each result is visible the cycle after its accept.
    task automatic test_alu_back_to_back();
        op_t         ops [14] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XORI, OP_SLL, OP_SRA,
                                  OP_SRLI, OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC, OP_ADDI, OP_SLTIU};
        logic [31:0] va [14] = '{32'h7FFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'd1,
                                 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                                 32'h0, 32'h10, 32'd3};
        logic [31:0] vb [14] = '{32'd1, 32'd7, 32'hFF00FF00, 32'h0F0F0000, 32'h0, 32'h21, 32'd4,
                                 32'h0, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] vi [14] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000FFFF, 32'h0, 32'h0, 32'd4,
                                 32'h0, 32'h0, 32'h12345000, 32'h20, 32'hFFFFFFFF, 32'd5};
        logic [31:0] ve [14] = '{32'h80000000, 32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'hFFFFFFFF,
                                 32'd2, 32'hF8000000, 32'h08000000, 32'd1, 32'd0, 32'h12345000,
                                 32'h120, 32'hF, 32'd1};
        for (int k = 0; k < 14; k++) begin
            drive(ops[k], va[k], vb[k], vi[k], 32'h100, 4'(k + 1));
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_valid[%0d]: got %b expected 1", k, out_valid); end
            n_checks++; if (out_data !== ve[k]) begin n_fail++; $display("[TB] FAIL alu_data[%0d]: got %h expected %h", k, out_data, ve[k]); end
            n_checks++; if (out_tag !== 4'(k + 1)) begin n_fail++; $display("[TB] FAIL alu_tag[%0d]: got %h expected %h", k, out_tag, 4'(k + 1)); end
        end
        drive(op_t'(6'h3F), 32'd5, 32'd6, 32'd7, 32'h100, 4'hE);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL unknown_op_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("[TB] FAIL unknown_op_data: got %h expected 0", out_data); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_divide();
        op_t         ops [11] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU,
                                  OP_REM, OP_DIV, OP_DIVU, OP_REM};
        logic [31:0] va [11] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000,
                                 32'd100, 32'd7, 32'd7, 32'd3, 32'hFFFFFFFD};
        logic [31:0] vb [11] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd10, 32'd10};
        logic [31:0] ve [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0,
                                 32'd14, 32'd1, 32'hFFFFFFFD, 32'd0, 32'hFFFFFFFD};
        int          vl [11] = '{34, 34, 2, 2, 2, 2, 34, 34, 34, LAT_EO, LAT_EO};
        for (int k = 0; k < 11; k++) begin
            int n = 1;
            int ready_bad = 0;
            drive(ops[k], va[k], vb[k], 32'h0, 32'h0, 4'(k + 3));
            tick();
            in_valid = 1'b0;
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL div_busy[%0d]: got %b expected 1", k, busy); end
            while (out_valid !== 1'b1 && n < 100) begin
                if (in_ready !== 1'b0) ready_bad++;
                tick();
                n++;
            end
            n_checks++; if (n != vl[k]) begin n_fail++; $display("[TB] FAIL div_latency[%0d]: got %0d expected %0d", k, n, vl[k]); end
            n_checks++; if (out_data !== ve[k]) begin n_fail++; $display("[TB] FAIL div_data[%0d]: got %h expected %h", k, out_data, ve[k]); end
            n_checks++; if (out_tag !== 4'(k + 3)) begin n_fail++; $display("[TB] FAIL div_tag[%0d]: got %h expected %h", k, out_tag, 4'(k + 3)); end
            n_checks++; if (ready_bad != 0) begin n_fail++; $display("[TB] FAIL div_in_ready[%0d]: got %0d high cycles expected 0", k, ready_bad); end
            tick();
        end
    endtask

    task automatic test_branch();
        op_t         ops [11] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BLT, OP_BLTU, OP_BGE, OP_BGEU,
                                  OP_BEQ, OP_JAL, OP_JALR, OP_JALR};
        logic [31:0] va [11] = '{32'd5, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1,
                                 32'd5, 32'd0, 32'h1001, 32'h1001};
        logic [31:0] vb [11] = '{32'd5, 32'd5, 32'd5, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd5, 32'd0, 32'd0, 32'd0};
        logic [31:0] vi [11] = '{32'h20, 32'h20, 32'h20, 32'h40, 32'h40, 32'h40, 32'h40, 32'h20,
                                 32'h40, 32'h10, 32'h10};
        logic [31:0] vp [11] = '{32'h100, 32'h100, 32'h100, 32'h200, 32'h200, 32'h200, 32'h200,
                                 32'h100, 32'h200, 32'h300, 32'h300};
        logic        vt [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] vg [11] = '{32'h0, 32'h120, 32'h120, 32'h0, 32'h0, 32'h240, 32'h240, 32'h124,
                                 32'h0, 32'h1010, 32'h1011};
        logic        er [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] ep [11] = '{32'h120, 32'h0, 32'h104, 32'h240, 32'h0, 32'h0, 32'h204, 32'h120,
                                 32'h240, 32'h0, 32'h1010};
        logic        eu [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] ed [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h204, 32'h304, 32'h304};
        for (int k = 0; k < 11; k++) begin
            drive(ops[k], va[k], vb[k], vi[k], vp[k], 4'(k));
            pred_taken  = vt[k];
            pred_target = vg[k];
            tick();
            in_valid = 1'b0;
            n_checks++; if (redirect_valid !== er[k]) begin n_fail++; $display("[TB] FAIL br_redirect[%0d]: got %b expected %b", k, redirect_valid, er[k]); end
            if (er[k]) begin
                n_checks++; if (redirect_pc !== ep[k]) begin n_fail++; $display("[TB] FAIL br_redirect_pc[%0d]: got %h expected %h", k, redirect_pc, ep[k]); end
            end
            n_checks++; if (out_valid !== eu[k]) begin n_fail++; $display("[TB] FAIL br_push[%0d]: got %b expected %b", k, out_valid, eu[k]); end
            if (eu[k]) begin
                n_checks++; if (out_data !== ed[k]) begin n_fail++; $display("[TB] FAIL br_link[%0d]: got %h expected %h", k, out_data, ed[k]); end
            end
            tick();
            n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL br_pulse[%0d]: got %b expected 0", k, redirect_valid); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 4'h1);
        tick();
        drive(OP_ADD, 32'd2, 32'd2, 32'h0, 32'h0, 4'h2);
        tick();
        drive(OP_ADD, 32'd3, 32'd3, 32'h0, 32'h0, 4'h3);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full_ready: got %b expected 0", in_ready); end
        tick();
        n_checks++; if (out_data !== 32'd2 || out_tag !== 4'h1) begin n_fail++; $display("[TB] FAIL bp_hold_head: got %h/%h expected 2/1", out_data, out_tag); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_pop_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_data !== 32'd4 || out_tag !== 4'h2) begin n_fail++; $display("[TB] FAIL bp_order2: got %h/%h expected 4/2", out_data, out_tag); end
        tick();
        n_checks++; if (out_data !== 32'd6 || out_tag !== 4'h3) begin n_fail++; $display("[TB] FAIL bp_order3: got %h/%h expected 6/3", out_data, out_tag); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        int stale = 0;
        drive(OP_DIV, 32'd100, 32'd3, 32'h0, 32'h0, 4'h9);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_pre_busy: got %b expected 1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready); end
        for (int c = 0; c < 40; c++) begin
            if (out_valid !== 1'b0) stale++;
            tick();
        end
        n_checks++; if (stale != 0) begin n_fail++; $display("[TB] FAIL flush_stale: got %0d valid cycles expected 0", stale); end

        out_ready = 1'b0;
        drive(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 4'h3);
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_fifo_fill: got %b expected 1", out_valid); end
        drive(OP_ADD, 32'd2, 32'd2, 32'h0, 32'h0, 4'h4);
        flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_cycle_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_fifo_empty: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_dropped: got %b expected 0", out_valid); end
        out_ready = 1'b1;

        drive(OP_DIVU, 32'd50, 32'd5, 32'h0, 32'h0, 4'h5);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid_div: got busy %b valid %b expected 0 0", busy, out_valid); end
        stale = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid !== 1'b0) stale++;
            tick();
        end
        n_checks++; if (stale != 0) begin n_fail++; $display("[TB] FAIL reset_stale: got %0d valid cycles expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_divide();
        test_branch();
        test_backpressure();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
